cache_bus_arbiter: RTL and testbench

//  Downstream of the cache top. Arbitrates inst-cache and data-cache miss/uncached requests onto one

---
 rtl/cache_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | Module  : cache_bus_arbiter                                                            |
// | Purpose : Arbitrates inst/data cache requests onto one SRAM-like bus, one transaction  |
// |           at a time; returns read data and a one-cycle done pulse to the owner.        |
// | Option  : ARB_ROUND_ROBIN_EN -- alternate grants on simultaneous requests.             |
// | Revision: 1.0 -- initial release                                                       |
// +----------------------------------------------------------------------------------------+
module cache_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_cache_req,
  input  logic [ADDR_W-1:0] inst_cache_addr,
  input  logic [1:0]        inst_cache_size,
  output logic [DATA_W-1:0] inst_cache_rdata,
  output logic              inst_cache_dok,
  input  logic              data_cache_req,
  input  logic [ADDR_W-1:0] data_cache_addr,
  input  logic              data_cache_wr,
  input  logic [1:0]        data_cache_size,
  input  logic [DATA_W-1:0] data_cache_wdata,
  output logic [DATA_W-1:0] data_cache_rdata,
  output logic              data_cache_dok,
  output logic              stall_by_arbitrater,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   gnt;
  logic   any_req;
  logic   pick_data;
  logic   grant_now;

  assign any_req   = inst_cache_req | data_cache_req;
  assign grant_now = (state == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers the side granted last; reset value means "inst was last" so data wins the first tie.
  logic last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b0;
    end else if (grant_now) begin
      last_gnt <= pick_data;
    end
  end

  assign pick_data = data_cache_req & (~inst_cache_req | ~last_gnt);
`else
  assign pick_data = data_cache_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = ADDR;
      ADDR:    if (bus_addr_ok) state_nxt = DATA;
      DATA:    if (bus_data_ok) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt              <= 1'b0;
      bus_wr           <= 1'b0;
      bus_size         <= 2'd0;
      bus_addr         <= '0;
      bus_wdata        <= '0;
      inst_cache_rdata <= '0;
      data_cache_rdata <= '0;
      inst_cache_dok   <= 1'b0;
      data_cache_dok   <= 1'b0;
    end else begin
      inst_cache_dok <= 1'b0;
      data_cache_dok <= 1'b0;
      if (grant_now) begin
        gnt       <= pick_data;
        bus_addr  <= pick_data ? data_cache_addr : inst_cache_addr;
        bus_size  <= pick_data ? data_cache_size : inst_cache_size;
        bus_wr    <= pick_data & data_cache_wr;
        bus_wdata <= pick_data ? data_cache_wdata : '0;
      end
      if ((state == DATA) && bus_data_ok) begin
        if (gnt) begin
          data_cache_rdata <= bus_rdata;
          data_cache_dok   <= 1'b1;
        end else begin
          inst_cache_rdata <= bus_rdata;
          inst_cache_dok   <= 1'b1;
        end
      end
    end
  end

  assign bus_req = (state == ADDR);

  // In DONE only the side that did not just finish can hold the pipeline.
  always_comb begin
    stall_by_arbitrater = 1'b0;
    case (state)
      IDLE:    stall_by_arbitrater = any_req;
      ADDR:    stall_by_arbitrater = 1'b1;
      DATA:    stall_by_arbitrater = 1'b1;
      DONE:    stall_by_arbitrater = gnt ? inst_cache_req : data_cache_req;
      default: stall_by_arbitrater = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// Self-checking bench for cache_bus_arbiter: vector table of single transactions plus
// hand-written sequences for ties, held requests, reset and protocol-error cases.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [1:0]  inst_cache_size;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        data_cache_req;
  logic [31:0] data_cache_addr;
  logic        data_cache_wr;
  logic [1:0]  data_cache_size;
  logic [31:0] data_cache_wdata;
  logic [31:0] data_cache_rdata;
  logic        data_cache_dok;
  logic        stall_by_arbitrater;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;
  logic model_last = 1'b0;

  cache_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
    .inst_cache_size(inst_cache_size), .inst_cache_rdata(inst_cache_rdata),
    .inst_cache_dok(inst_cache_dok),
    .data_cache_req(data_cache_req), .data_cache_addr(data_cache_addr),
    .data_cache_wr(data_cache_wr), .data_cache_size(data_cache_size),
    .data_cache_wdata(data_cache_wdata), .data_cache_rdata(data_cache_rdata),
    .data_cache_dok(data_cache_dok),
    .stall_by_arbitrater(stall_by_arbitrater),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        side;      // 1 = data cache, 0 = inst cache
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          aw;        // ADDR cycles before addr_ok
    int          dw;        // DATA cycles before data_ok
    logic [31:0] rd;
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered post-edge in IDLE with requests already driven; leaves in the DONE (dok) cycle.
  task automatic serve(input logic side, input logic [31:0] ea, input logic ew,
                       input logic [1:0] es, input logic [31:0] ewd,
                       input int aw, input int dw, input logic [31:0] rd);
    tick();
    chk("bus_req_rise", bus_req, 1);
    chk("bus_addr", bus_addr, ea);
    chk("bus_wr", bus_wr, ew);
    chk("bus_size", bus_size, es);
    chk("bus_wdata", bus_wdata, ewd);
    chk("stall_addr", stall_by_arbitrater, 1);
    for (int i = 0; i < aw; i++) begin
      tick();
      chk("bus_req_hold", bus_req, 1);
      chk("bus_addr_hold", bus_addr, ea);
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    chk("bus_req_data", bus_req, 0);
    chk("stall_data", stall_by_arbitrater, 1);
    for (int i = 0; i < dw; i++) begin
      tick();
      chk("dok_early", {inst_cache_dok, data_cache_dok}, 0);
    end
    bus_data_ok = 1'b1;
    bus_rdata   = rd;
    tick();
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    chk("dok_owner", side ? data_cache_dok : inst_cache_dok, 1);
    chk("dok_other", side ? inst_cache_dok : data_cache_dok, 0);
    chk("rdata", side ? data_cache_rdata : inst_cache_rdata, rd);
    chk("stall_done", stall_by_arbitrater, side ? inst_cache_req : data_cache_req);
    model_last = side;
  endtask

  task automatic tie(input logic [31:0] rd_a, input logic [31:0] rd_b);
    logic first;
`ifdef ARB_ROUND_ROBIN_EN
    first = ~model_last;
`else
    first = 1'b1;
`endif
    inst_cache_req   = 1'b1; inst_cache_addr = 32'hBFC00100; inst_cache_size = 2'd2;
    data_cache_req   = 1'b1; data_cache_addr = 32'h80003000; data_cache_size = 2'd2;
    data_cache_wr    = 1'b1; data_cache_wdata = 32'h11223344;
    #1;
    chk("tie_stall", stall_by_arbitrater, 1);
    for (int k = 0; k < 2; k++) begin
      logic s;
      s = (k == 0) ? first : ~first;
      serve(s, s ? 32'h80003000 : 32'hBFC00100, s, 2'd2, s ? 32'h11223344 : 32'h0,
            0, 0, (k == 0) ? rd_a : rd_b);
      if (s) data_cache_req = 1'b0; else inst_cache_req = 1'b0;
      tick();
      chk("tie_gap_dok", {inst_cache_dok, data_cache_dok}, 0);
      chk("tie_gap_busreq", bus_req, 0);
    end
    chk("tie_end_stall", stall_by_arbitrater, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'hBFC00000, 1'b1, 2'd2, 32'hA5A5A5A5, 2, 2, 32'h3C1DBFC0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h80001000, 1'b1, 2'd0, 32'h000000EF, 0, 1, 32'h12345678, 1'b1, 32'h000000EF};
    vecs[2] = '{1'b1, 32'h80002004, 1'b0, 2'd2, 32'h55AA55AA, 1, 0, 32'hDEADBEEF, 1'b0, 32'h55AA55AA};
    vecs[3] = '{1'b0, 32'hBFC00010, 1'b1, 2'd1, 32'hFFFFFFFF, 0, 0, 32'h0BADF00D, 1'b0, 32'h0};

    rst = 1'b1;
    inst_cache_req = 0; inst_cache_addr = 0; inst_cache_size = 0;
    data_cache_req = 0; data_cache_addr = 0; data_cache_wr = 0; data_cache_size = 0;
    data_cache_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata} != 0, 0);
    chk("rst_rdata", inst_cache_rdata | data_cache_rdata, 0);
    chk("rst_dok", {inst_cache_dok, data_cache_dok}, 0);
    chk("rst_stall", stall_by_arbitrater, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].side) begin
        data_cache_req = 1'b1; data_cache_addr = vecs[v].addr; data_cache_wr = vecs[v].wr;
        data_cache_size = vecs[v].size; data_cache_wdata = vecs[v].wdata;
        inst_cache_addr = ~vecs[v].addr; inst_cache_size = 2'd3;
      end else begin
        inst_cache_req = 1'b1; inst_cache_addr = vecs[v].addr; inst_cache_size = vecs[v].size;
        data_cache_addr = ~vecs[v].addr; data_cache_wr = vecs[v].wr;
        data_cache_size = 2'd3; data_cache_wdata = vecs[v].wdata;
      end
      #1;
      chk("idle_req_stall", stall_by_arbitrater, 1);
      chk("idle_no_busreq", bus_req, 0);
      serve(vecs[v].side, vecs[v].addr, vecs[v].exp_wr, vecs[v].size, vecs[v].exp_wdata,
            vecs[v].aw, vecs[v].dw, vecs[v].rd);
      inst_cache_req = 1'b0; data_cache_req = 1'b0;
      tick();
      chk("post_dok", {inst_cache_dok, data_cache_dok}, 0);
      chk("post_busreq", bus_req, 0);
      chk("post_stall", stall_by_arbitrater, 0);
    end
    chk("data_rdata_held", data_cache_rdata, 32'hDEADBEEF);
    chk("inst_rdata_held", inst_cache_rdata, 32'h0BADF00D);

    tie(32'h000000AA, 32'h000000BB);

    // Data request held through the dok cycle must not be reissued.
    data_cache_req = 1'b1; data_cache_addr = 32'h80006000; data_cache_wr = 1'b0;
    data_cache_size = 2'd2; data_cache_wdata = 32'h0;
    #1;
    serve(1'b1, 32'h80006000, 1'b0, 2'd2, 32'h0, 0, 0, 32'h00000066);
    tick();
    data_cache_req = 1'b0;
    #1;
    chk("held_idle_busreq", bus_req, 0);
    chk("held_idle_dok", data_cache_dok, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_no_reissue", bus_req, 0);
    end

    tie(32'h000000CC, 32'h000000DD);

    // data_ok during ADDR is ignored.
    data_cache_req = 1'b1; data_cache_addr = 32'h80004000; data_cache_wr = 1'b0;
    data_cache_size = 2'd2;
    tick();
    chk("perr_in_addr", bus_req, 1);
    bus_data_ok = 1'b1; bus_rdata = 32'hFFFF0000;
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    chk("perr_still_addr", bus_req, 1);
    tick();
    chk("perr_no_dok", data_cache_dok, 0);
    chk("perr_busreq", bus_req, 1);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h00000044;
    tick();
    bus_data_ok = 1'b0;
    chk("perr_dok", data_cache_dok, 1);
    chk("perr_rdata", data_cache_rdata, 32'h00000044);
    data_cache_req = 1'b0;
    tick();

    // Reset while in DATA; a late data_ok must not produce a dok.
    data_cache_req = 1'b1; data_cache_addr = 32'h80005000; data_cache_wr = 1'b1;
    data_cache_size = 2'd1; data_cache_wdata = 32'h0000BEEF;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    chk("rst_mid_in_data", bus_req, 0);
    data_cache_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_addr", bus_addr, 0);
    chk("rst_mid_fields", {bus_wr, bus_size, bus_wdata} != 0, 0);
    chk("rst_mid_rdata", data_cache_rdata | inst_cache_rdata, 0);
    chk("rst_mid_stall", stall_by_arbitrater, 0);
    tick();
    rst = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h77777777;
    tick();
    bus_data_ok = 1'b0;
    chk("rst_late_dok", {inst_cache_dok, data_cache_dok}, 0);
    chk("rst_late_busreq", bus_req, 0);
    tick();
    chk("rst_late_dok2", {inst_cache_dok, data_cache_dok}, 0);
    chk("rst_late_rdata", data_cache_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
